// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman guess checker.
package hangman_pkg;

    localparam int unsigned WORD_LEN     = 5;
    localparam int unsigned MAX_MISTAKES = 6;
    localparam int unsigned LETTER_W     = 8;
    localparam int unsigned ALPHA_N      = 26;

    localparam logic [LETTER_W-1:0] ASCII_A = 8'h41;
    localparam logic [LETTER_W-1:0] ASCII_Z = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GUESS,
        SCAN,
        WON,
        LOST
    } state_e;

    // True for an uppercase ASCII letter.
    function automatic logic is_upper(input logic [LETTER_W-1:0] c);
        return (c >= ASCII_A) && (c <= ASCII_Z);
    endfunction

endpackage

// File: rtl/guess_checker_if.sv
// Word/guess request and evaluation result bundle of the guess checker.
interface guess_checker_if #(
    parameter int unsigned WORD_LEN     = hangman_pkg::WORD_LEN,
    parameter int unsigned MAX_MISTAKES = hangman_pkg::MAX_MISTAKES
);
    localparam int unsigned CNT_W = $clog2(WORD_LEN + 1);
    localparam int unsigned MIS_W = $clog2(MAX_MISTAKES + 1);

    logic [8*WORD_LEN-1:0] word;
    logic                  word_load;
    logic [7:0]            guess;
    logic                  guess_valid;

    logic                  ready;
    logic [7:0]            letter;
    logic [WORD_LEN-1:0]   indexCorrect;
    logic [CNT_W-1:0]      correct;
    logic                  mistake;
    logic [MIS_W-1:0]      numMistake;
    logic [WORD_LEN-1:0]   found;
    logic                  result_valid;
    logic                  dup;
    logic                  won;
    logic                  lost;

    modport master (
        output word, word_load, guess, guess_valid,
        input  ready, letter, indexCorrect, correct, mistake, numMistake,
               found, result_valid, dup, won, lost
    );

    modport slave (
        input  word, word_load, guess, guess_valid,
        output ready, letter, indexCorrect, correct, mistake, numMistake,
               found, result_valid, dup, won, lost
    );
endinterface

// File: rtl/letter_decode.sv
// ASCII uppercase letter to 26-bit one-hot; non-letters decode to zero.
module letter_decode
    import hangman_pkg::*;
(
    input  logic [LETTER_W-1:0] ascii,
    output logic [ALPHA_N-1:0]  onehot_c
);
    always_comb begin
        onehot_c = '0;
        if (is_upper(ascii)) begin
            onehot_c = ALPHA_N'(1) << 5'(ascii - ASCII_A);
        end
    end
endmodule

// File: rtl/guess_checker.sv
// Hangman guess checker: scans the secret word one letter per cycle and
// tracks revealed positions, repeated guesses and mistakes.
module guess_checker
    import hangman_pkg::*;
#(
    parameter int unsigned WORD_LEN     = hangman_pkg::WORD_LEN,
    parameter int unsigned MAX_MISTAKES = hangman_pkg::MAX_MISTAKES
) (
    input  logic            clk,
    input  logic            nRst,
    guess_checker_if.slave  bus
);
    localparam int unsigned POS_W  = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam int unsigned CNT_W  = $clog2(WORD_LEN + 1);
    localparam int unsigned MIS_W  = $clog2(MAX_MISTAKES + 1);
    localparam int unsigned WORD_W = 8 * WORD_LEN;

    localparam logic [WORD_LEN-1:0] ALL_FOUND = '1;
    localparam logic [MIS_W-1:0]    MIS_MAX   = MIS_W'(MAX_MISTAKES);

    state_e                state_q, state_nxt;
    logic [WORD_W-1:0]     word_q, word_nxt;
    logic [LETTER_W-1:0]   guess_q, guess_nxt;
    logic [POS_W-1:0]      pos_q, pos_nxt;
    logic [WORD_LEN-1:0]   mask_q, mask_nxt;
    logic [ALPHA_N-1:0]    guessed_q, guessed_nxt;
    logic [LETTER_W-1:0]   letter_q, letter_nxt;
    logic [WORD_LEN-1:0]   index_q, index_nxt;
    logic [CNT_W-1:0]      correct_q, correct_nxt;
    logic                  mistake_q, mistake_nxt;
    logic                  dup_q, dup_nxt;
    logic [MIS_W-1:0]      num_mis_q, num_mis_nxt;
    logic [WORD_LEN-1:0]   found_q, found_nxt;
    logic                  result_valid_q, result_valid_nxt;
    logic                  won_q, won_nxt;
    logic                  lost_q, lost_nxt;
    logic                  ready_q, ready_nxt;

    logic [ALPHA_N-1:0]    guess_onehot_c;
    logic [LETTER_W-1:0]   cur_byte;
    logic                  hit;
    logic [WORD_LEN-1:0]   scan_mask;
    logic [CNT_W-1:0]      pop;

    letter_decode u_letter_decode (
        .ascii    (guess_q),
        .onehot_c (guess_onehot_c)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q        <= IDLE;
            word_q         <= '0;
            guess_q        <= '0;
            pos_q          <= '0;
            mask_q         <= '0;
            guessed_q      <= '0;
            letter_q       <= '0;
            index_q        <= '0;
            correct_q      <= '0;
            mistake_q      <= 1'b0;
            dup_q          <= 1'b0;
            num_mis_q      <= '0;
            found_q        <= '0;
            result_valid_q <= 1'b0;
            won_q          <= 1'b0;
            lost_q         <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            word_q         <= word_nxt;
            guess_q        <= guess_nxt;
            pos_q          <= pos_nxt;
            mask_q         <= mask_nxt;
            guessed_q      <= guessed_nxt;
            letter_q       <= letter_nxt;
            index_q        <= index_nxt;
            correct_q      <= correct_nxt;
            mistake_q      <= mistake_nxt;
            dup_q          <= dup_nxt;
            num_mis_q      <= num_mis_nxt;
            found_q        <= found_nxt;
            result_valid_q <= result_valid_nxt;
            won_q          <= won_nxt;
            lost_q         <= lost_nxt;
            ready_q        <= ready_nxt;
        end
    end

    // Byte under the scan pointer; position WORD_LEN-1 is the leftmost letter.
    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            if (pos_q == POS_W'(i)) begin
                cur_byte = word_q[i*8 +: 8];
            end
        end
        hit       = (cur_byte == guess_q);
        scan_mask = mask_q | (WORD_LEN'(hit) << pos_q);
        pop       = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            pop = pop + CNT_W'(scan_mask[i]);
        end
    end

    always_comb begin
        state_nxt        = state_q;
        word_nxt         = word_q;
        guess_nxt        = guess_q;
        pos_nxt          = pos_q;
        mask_nxt         = mask_q;
        guessed_nxt      = guessed_q;
        letter_nxt       = letter_q;
        index_nxt        = index_q;
        correct_nxt      = correct_q;
        mistake_nxt      = mistake_q;
        dup_nxt          = dup_q;
        num_mis_nxt      = num_mis_q;
        found_nxt        = found_q;
        result_valid_nxt = 1'b0;
        won_nxt          = won_q;
        lost_nxt         = lost_q;

        // A load restarts the game from any state and drops any guess.
        if (bus.word_load) begin
            state_nxt   = WAIT_GUESS;
            word_nxt    = bus.word;
            guess_nxt   = '0;
            pos_nxt     = '0;
            mask_nxt    = '0;
            guessed_nxt = '0;
            letter_nxt  = '0;
            index_nxt   = '0;
            correct_nxt = '0;
            mistake_nxt = 1'b0;
            dup_nxt     = 1'b0;
            num_mis_nxt = '0;
            found_nxt   = '0;
            won_nxt     = 1'b0;
            lost_nxt    = 1'b0;
        end else begin
            unique case (state_q)
                WAIT_GUESS: begin
                    if (bus.guess_valid && is_upper(bus.guess)) begin
                        state_nxt = SCAN;
                        guess_nxt = bus.guess;
                        pos_nxt   = POS_W'(WORD_LEN - 1);
                        mask_nxt  = '0;
                    end
                end
                SCAN: begin
                    mask_nxt = scan_mask;
                    pos_nxt  = pos_q - POS_W'(1);
                    if (pos_q == '0) begin
                        result_valid_nxt = 1'b1;
                        letter_nxt       = guess_q;
                        if (|(guessed_q & guess_onehot_c)) begin
                            dup_nxt     = 1'b1;
                            index_nxt   = '0;
                            correct_nxt = '0;
                            mistake_nxt = 1'b0;
                        end else begin
                            guessed_nxt = guessed_q | guess_onehot_c;
                            dup_nxt     = 1'b0;
                            index_nxt   = scan_mask;
                            correct_nxt = pop;
                            mistake_nxt = (scan_mask == '0);
                            found_nxt   = found_q | scan_mask;
                            if ((scan_mask == '0) && (num_mis_q < MIS_MAX)) begin
                                num_mis_nxt = num_mis_q + MIS_W'(1);
                            end
                        end
                        if (found_nxt == ALL_FOUND) begin
                            state_nxt = WON;
                            won_nxt   = 1'b1;
                        end else if (num_mis_nxt == MIS_MAX) begin
                            state_nxt = LOST;
                            lost_nxt  = 1'b1;
                        end else begin
                            state_nxt = WAIT_GUESS;
                        end
                    end
                end
                IDLE, WON, LOST: begin
                    state_nxt = state_q;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        ready_nxt = (state_nxt == WAIT_GUESS);
    end

    assign bus.ready        = ready_q;
    assign bus.letter       = letter_q;
    assign bus.indexCorrect = index_q;
    assign bus.correct      = correct_q;
    assign bus.mistake      = mistake_q;
    assign bus.numMistake   = num_mis_q;
    assign bus.found        = found_q;
    assign bus.result_valid = result_valid_q;
    assign bus.dup          = dup_q;
    assign bus.won          = won_q;
    assign bus.lost         = lost_q;

endmodule

// File: doc/guess_checker.md
GUESS_CHECKER -- requirements
Module: guess_checker

Interface
REQ-001 SHALL have parameter WORD_LEN, default 5, number of letters per secret word.
REQ-002 SHALL have parameter MAX_MISTAKES, default 6, mistakes that end the game as lost.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port nRst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port word  input  40  secret word, ASCII; word[39:32] is the first (leftmost) letter.
REQ-006 SHALL have port word_load  input  1  one-cycle strobe; captures word and starts a new game.
REQ-007 SHALL have port guess  input  8  guessed letter, uppercase ASCII.
REQ-008 SHALL have port guess_valid  input  1  one-cycle strobe qualifying guess.
REQ-009 SHALL have port ready  output  1  high when a guess is accepted this cycle.
REQ-010 SHALL have port letter  output  8  last evaluated guess, held.
REQ-011 SHALL have port indexCorrect  output  5  positions matching the last guess; bit4 = first letter.
REQ-012 SHALL have port correct  output  3  popcount of indexCorrect.
REQ-013 SHALL have port mistake  output  1  last guess was a new letter not in the word.
REQ-014 SHALL have port numMistake  output  3  cumulative mistakes this game.
REQ-015 SHALL have port found  output  5  cumulative revealed-position mask.
REQ-016 SHALL have port result_valid  output  1  one-cycle pulse; evaluation outputs just updated.
REQ-017 SHALL have port dup  output  1  last guess had already been guessed this game.
REQ-018 SHALL have port won / lost  output  1 each  game-over flags, held until word_load or reset.

Function
REQ-019 SHALL implement the FSM states IDLE, WAIT_GUESS, SCAN, WON and LOST.
REQ-020 In IDLE, word_load SHALL capture word, clear found, numMistake and the 26-bit guessed-letter mask, and go to WAIT_GUESS.
REQ-021 In WAIT_GUESS, ready SHALL be 1; guess_valid with guess in 0x41..0x5A SHALL latch guess and enter SCAN with a position counter at WORD_LEN-1.
REQ-022 guess_valid with guess outside 0x41..0x5A SHALL be ignored, with no output change and no result_valid pulse.
REQ-023 SCAN SHALL compare one byte per cycle, positions 4 down to 0, taking exactly WORD_LEN cycles.
REQ-024 Latency: for a guess accepted at edge E, outputs SHALL update and result_valid SHALL be 1 after edge E+5.
REQ-025 For a new letter with one or more matches: indexCorrect = match mask, correct = popcount, mistake=0, found |= mask.
REQ-026 For a new letter with zero matches: indexCorrect=0, correct=0, mistake=1, numMistake+1.
REQ-027 For an already-guessed letter: dup=1, indexCorrect=0, correct=0, mistake=0; numMistake and found SHALL be unchanged.
REQ-028 After the result, the next state SHALL be WON if found is all ones, else LOST if numMistake == MAX_MISTAKES, else WAIT_GUESS.
REQ-029 numMistake SHALL saturate at MAX_MISTAKES.
REQ-030 In SCAN, WON and LOST, ready SHALL be 0 and guess_valid SHALL be ignored.
REQ-031 word_load SHALL be honoured in any state, restart the game, and abort any in-progress SCAN without a result_valid pulse.
REQ-032 word_load asserted in the same cycle as guess_valid: word_load SHALL win and the guess SHALL be dropped.
REQ-033 letter, indexCorrect, correct, mistake and dup SHALL hold until the next result or restart; a restart SHALL clear them.

Reset
REQ-034 nRst low SHALL asynchronously force state IDLE and clear all outputs and internal registers to 0, including ready=0.
REQ-035 Reset mid-SCAN SHALL discard the guess with no result_valid pulse.

Structure
REQ-036 A shared package hangman_pkg SHALL hold the state enum, WORD_LEN, MAX_MISTAKES, and ASCII_A/ASCII_Z constants.
REQ-037 The sub-module letter_decode SHALL map ASCII to a 26-bit one-hot code for the guessed-letter mask; it SHALL be combinational.
REQ-038 All outputs SHALL be driven from registers.

Verification (word = "APPLE", 0x4150504C45)
REQ-039 Reset, then load, then guess 'A' -> after 5 SCAN cycles, indexCorrect=10000, correct=1, mistake=0, result_valid pulses once.
REQ-040 Guess 'P' -> indexCorrect=01100, correct=2; guess 'P' again -> dup=1, correct=0, numMistake unchanged.
REQ-041 Guess 'B' -> mistake=1, numMistake=1, indexCorrect=00000.
REQ-042 Guesses A, P, L, E -> found=11111, won=1, ready=0; a further guess_valid SHALL be ignored.
REQ-043 Six distinct wrong letters -> numMistake=6, lost=1; then word_load -> all cleared and ready=1.
REQ-044 nRst low on the 3rd SCAN cycle -> no result_valid, outputs 0, state IDLE; word_load with guess_valid in the same cycle -> guess dropped.
